register_file_mp: RTL and testbench

//  Parametrised dual-write, dual-read integer register file for the single-cycle core.

---
 rtl/register_file_mp.sv | 134 +++++++++++++
 tb/tb_register_file_mp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//   Parametrised integer register file with two write ports and two
//   combinational read ports. Register 0 is hard-wired to zero. After reset
//   the file zeroes registers 1..NREGS-1, one per clock, before it accepts
//   writes or returns stored data. A same-address write on both ports is
//   resolved in favour of port B and reported one cycle later.
//
// Configuration macro:
//   RF_BYPASS_EN  when defined, a write in progress to a read address is
//                 forwarded to that read port in the same cycle (port B
//                 data takes priority over port A).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   rf_ready     1 once the clear has finished (writes accepted, reads valid)
//   we_a/wa_a/wd_a  write port A (ALU writeback)
//   we_b/wa_b/wd_b  write port B (load / late writeback)
//   a1/a2        read addresses
//   rd1/rd2      read data, combinational
//   wr_conflict  one-cycle pulse: both ports wrote the same nonzero address
// ---------------------------------------------------------------------------
module register_file_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rf_ready,
  input  logic            we_a,
  input  logic [AW-1:0]   wa_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   wa_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            wr_conflict
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            wr_conflict_q, wr_conflict_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic accept;
  logic wr_a_en;
  logic wr_b_en;
  logic same_addr;

  // The file is only usable in RUN and outside reset; everything else is
  // gated by this single qualifier so writes, forwarding and reads agree.
  assign accept    = (state_q == RUN) && !rst;
  assign wr_a_en   = accept && we_a && (wa_a != '0);
  assign wr_b_en   = accept && we_b && (wa_b != '0);
  assign same_addr = wr_a_en && wr_b_en && (wa_a == wa_b);

  assign rf_ready    = accept;
  assign wr_conflict = wr_conflict_q;

  // Next-state logic: CLEAR walks clr_cnt from 1 up to NREGS-1 and moves to
  // RUN on the cycle that writes the last register. RUN is left only by rst.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wr_conflict_d = same_addr;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NREGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  // State register plus storage. The array is not reset directly; the clear
  // sequence zeroes it. Port A is suppressed on a same-address collision so
  // port B's data is the one stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= AW'(1);
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_conflict_q <= wr_conflict_d;
      if (state_q == CLEAR) begin
        regs_q[clr_cnt_q] <= '0;
      end
      if (wr_a_en && !same_addr) begin
        regs_q[wa_a] <= wd_a;
      end
      if (wr_b_en) begin
        regs_q[wa_b] <= wd_b;
      end
    end
  end

  // Read ports. Address 0 and a not-ready file both read as zero; with
  // forwarding enabled the port B check comes last so it has priority.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (accept && (a1 != '0)) begin
      rd1 = regs_q[a1];
`ifdef RF_BYPASS_EN
      if (wr_a_en && (wa_a == a1)) rd1 = wd_a;
      if (wr_b_en && (wa_b == a1)) rd1 = wd_b;
`endif
    end
    if (accept && (a2 != '0)) begin
      rd2 = regs_q[a2];
`ifdef RF_BYPASS_EN
      if (wr_a_en && (wa_a == a2)) rd2 = wd_a;
      if (wr_b_en && (wa_b == a2)) rd2 = wd_b;
`endif
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
//   Self-checking bench for register_file_mp. A behavioural model (an array
//   of register values, a clear-step counter and a ready bit) tracks what the
//   file must hold; a compare process checks every DUT output against it on
//   each falling edge. Directed scenarios pin the model with literal values,
//   then randomized traffic (with occasional resets) exercises the rest.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst;
  logic            rf_ready;
  logic            we_a;
  logic [AW-1:0]   wa_a;
  logic [XLEN-1:0] wd_a;
  logic            we_b;
  logic [AW-1:0]   wa_b;
  logic [XLEN-1:0] wd_b;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            wr_conflict;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 1'b0;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .rf_ready(rf_ready),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .wr_conflict(wr_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a ready flag, the number of clear cycles seen since
  // reset, the architectural register values and the pending conflict flag.
  bit              mReady = 1'b0;
  int              mSteps = 0;
  logic [XLEN-1:0] mRegs [NREGS];
  bit              mConf  = 1'b0;

  initial begin
    for (int i = 0; i < NREGS; i++) mRegs[i] = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      mReady <= 1'b0;
      mSteps <= 0;
      mConf  <= 1'b0;
    end else if (!mReady) begin
      mConf <= 1'b0;
      if (mSteps + 1 == NREGS - 1) begin
        mReady <= 1'b1;
        for (int i = 0; i < NREGS; i++) mRegs[i] <= '0;
      end
      mSteps <= mSteps + 1;
    end else begin
      mConf <= (we_a && wa_a != 0 && we_b && wa_b != 0 && wa_a == wa_b);
      if (we_a && wa_a != 0 && !(we_b && wa_b == wa_a)) mRegs[wa_a] <= wd_a;
      if (we_b && wa_b != 0) mRegs[wa_b] <= wd_b;
    end
  end

  function automatic logic [XLEN-1:0] modelRead(input logic [AW-1:0] addr);
    logic [XLEN-1:0] v;
    v = '0;
    if (mReady && !rst && addr != 0) begin
      v = mRegs[addr];
      if (BYPASS) begin
        if (we_b && wa_b == addr) v = wd_b;
        else if (we_a && wa_a == addr) v = wd_a;
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("rf_ready", {31'b0, rf_ready}, {31'b0, mReady && !rst});
      checkOutput("rd1", rd1, modelRead(a1));
      checkOutput("rd2", rd2, modelRead(a2));
      checkOutput("wr_conflict", {31'b0, wr_conflict}, {31'b0, mConf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit wea, input logic [AW-1:0] waa,
                               input logic [XLEN-1:0] wda, input bit web,
                               input logic [AW-1:0] wab, input logic [XLEN-1:0] wdb,
                               input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    rst = r; we_a = wea; wa_a = waa; wd_a = wda;
    we_b = web; wa_b = wab; wd_b = wdb; a1 = ra1; a2 = ra2;
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra1, ra2);
  endtask

  // Counts cycles of rf_ready=0 after reset release; bounded so a stuck
  // clear still reaches the summary.
  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!rf_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput(name, n, NREGS - 1);
  endtask

  task automatic pulseReset(input int cycles);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    repeat (cycles) tick();
    idle('0, '0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    tick();
    cmpOn = 1'b1;
    tick();

    // Reset release: exactly NREGS-1 not-ready cycles, then all zeros.
    idle('0, '0);
    checkOutput("ready low after reset", {31'b0, rf_ready}, 32'd0);
    waitReady("clear length");
    for (int i = 0; i < NREGS; i++) begin
      idle(AW'(i), AW'(NREGS - 1 - i));
      checkOutput("cleared rd1", rd1, 32'd0);
      checkOutput("cleared rd2", rd2, 32'd0);
    end

    // Simple write and read-back, with and without forwarding.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h0000_0006, 1'b0, '0, '0, 5'd5, 5'd0);
    checkOutput("same-cycle rd1", rd1, BYPASS ? 32'h6 : 32'h0);
    tick();
    idle(5'd5, 5'd5);
    checkOutput("reg5 readback", rd1, 32'h6);
    checkOutput("model reg5", mRegs[5], 32'h6);

    // Same-address collision: port B wins, one-cycle conflict pulse.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555, 5'd7, 5'd0);
    checkOutput("collide fwd", rd1, BYPASS ? 32'h5555_5555 : 32'h0);
    tick();
    idle(5'd7, 5'd0);
    checkOutput("conflict pulse", {31'b0, wr_conflict}, 32'd1);
    checkOutput("reg7 port B wins", rd1, 32'h5555_5555);
    checkOutput("model reg7", mRegs[7], 32'h5555_5555);
    tick();
    checkOutput("conflict clears", {31'b0, wr_conflict}, 32'd0);

    // Writes to address 0 are dropped and never flag a conflict.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    checkOutput("x0 same cycle", rd1, 32'h0);
    tick();
    idle(5'd0, 5'd0);
    checkOutput("x0 after write", rd1, 32'h0);
    checkOutput("x0 no conflict", {31'b0, wr_conflict}, 32'd0);

    // Reset in RUN wipes reg3.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'd9, 1'b0, '0, '0, 5'd0, 5'd3);
    tick();
    idle(5'd0, 5'd3);
    checkOutput("reg3 written", rd2, 32'd9);
    pulseReset(1);
    checkOutput("ready low after run reset", {31'b0, rf_ready}, 32'd0);
    waitReady("clear length after run reset");
    idle(5'd0, 5'd3);
    checkOutput("reg3 cleared", rd2, 32'd0);

    // Reset mid-clear restarts; writes during the clear are ignored.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'd9, 1'b0, '0, '0, 5'd0, 5'd3);
    tick();
    pulseReset(1);
    repeat (10) begin
      applyStimulus(1'b0, 1'b1, 5'd4, 32'd1, 1'b0, '0, '0, 5'd4, 5'd3);
      checkOutput("read during clear", rd2, 32'd0);
      tick();
    end
    pulseReset(1);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'd1, 1'b0, '0, '0, 5'd4, 5'd3);
    waitReady("clear length after mid-clear reset");
    idle(5'd4, 5'd3);
    checkOutput("reg4 write ignored", rd1, 32'd0);
    checkOutput("reg3 after restart", rd2, 32'd0);

    // Randomized traffic; narrow address ranges now and then to force
    // collisions, and rare resets to revisit the clear sequence.
    for (int n = 0; n < 4000; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 3) == 0);
      applyStimulus(($urandom_range(0, 599) == 0),
                    1'($urandom), narrow ? AW'($urandom_range(0, 2)) : AW'($urandom),
                    $urandom,
                    1'($urandom), narrow ? AW'($urandom_range(0, 2)) : AW'($urandom),
                    $urandom,
                    AW'($urandom), narrow ? AW'($urandom_range(0, 2)) : AW'($urandom));
      tick();
    end
    idle('0, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
